fetch_unit: RTL and testbench

Instruction-fetch stage that produces the PC/incremented-PC/instruction triple consumed by the IF/ID pipeline register. Owns the program counter and drives a request/ready instruction-memory port that tolerates variable latency. Absorbs hazard-unit stalls with a one-entry hold buffer, flushes on branch/jump redirects, and stops fetching after a HALT.

---
 rtl/fetch_unit_pkg.sv | 32 +++
 rtl/fetch_unit_if.sv | 10 +
 rtl/dff_16bit.sv | 23 ++
 rtl/fetch_hold_buffer.sv | 38 +++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  // Instruction word that the decode stage treats as a no-op bubble.
  localparam logic [15:0] NOP_WORD = 16'h0800;

  // HALT is recognised purely from the opcode field.
  localparam logic [4:0] HALT_OPCODE = 5'b00000;
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 11;

  // Byte distance between consecutive 16-bit instructions.
  localparam logic [15:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // What the IF/ID register consumes, and what the hold buffer stores.
  typedef struct packed {
    logic [15:0] pc_curr;
    logic [15:0] pc_inc;
    logic [15:0] inst;
  } fetch_triple_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPCODE_HI:OPCODE_LO] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready port. The fetch unit is the master.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/dff_16bit.sv
// 16-bit register with synchronous reset and load enable.
module dff_16bit #(
  parameter logic [15:0] reset_value = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Load d when enabled; reset wins.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values,
    // independent of the order in which always blocks are evaluated.
    if (rst) begin
      q <= reset_value;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_hold_buffer.sv
// One-entry skid buffer that parks a fetched triple while the IF/ID stage stalls.
module fetch_hold_buffer
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  fetch_triple_t d,
  output fetch_triple_t q,
  output logic          valid
);

  logic [15:0] pc_curr_q;
  logic [15:0] pc_inc_q;
  logic [15:0] inst_q;

  // NOTE: only valid decides whether the entry is used; the payload registers
  // are reset as well simply because dff_16bit always resets.
  dff_16bit u_pc_curr (.clk(clk), .rst(rst), .en(load), .d(d.pc_curr), .q(pc_curr_q));
  dff_16bit u_pc_inc  (.clk(clk), .rst(rst), .en(load), .d(d.pc_inc),  .q(pc_inc_q));
  dff_16bit #(.reset_value(NOP_WORD))
            u_inst    (.clk(clk), .rst(rst), .en(load), .d(d.inst),    .q(inst_q));

  assign q = '{pc_curr: pc_curr_q, pc_inc: pc_inc_q, inst: inst_q};

  // Occupancy flag: load fills the entry, clear empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory, absorbs stalls with a one-entry hold buffer, flushes on redirect and
// stops requesting after a HALT.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic                fetch_valid,
  output logic [15:0]         PCCurrOut,
  output logic [15:0]         PCIncOut,
  output logic [15:0]         InstOut
);

  fetch_state_t  state, state_next;
  logic [15:0]   pc, pc_d, pc_plus, drain_addr, addr;
  logic          pc_en, drain_en;
  logic          hb_load, hb_clear, hb_valid;
  logic          out_load, out_bubble;
  logic          req, accept;
  logic [15:0]   inst_d;
  fetch_triple_t fetched, hb_q, out_d;

  assign pc_plus = pc + PC_STEP;
  assign fetched = '{pc_curr: pc, pc_inc: pc_plus, inst: imem.imem_data};

  // Request and address depend only on registered state, never on imem_ready.
  // In DRAIN the old address is replayed even though the PC already moved on.
  assign req            = ((state == ST_FETCH) && !hb_valid) || (state == ST_DRAIN);
  assign addr           = (state == ST_DRAIN) ? drain_addr : pc;
  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  // A returned word is only usable in FETCH; in DRAIN it belongs to a flushed path.
  assign accept = (state == ST_FETCH) && req && imem.imem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state, PC update, hold-buffer and output-register control.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_d       = pc_plus;
    pc_en      = 1'b0;
    drain_en   = 1'b0;
    hb_load    = 1'b0;
    hb_clear   = 1'b0;
    out_load   = 1'b0;
    out_bubble = 1'b0;
    out_d      = fetched;

    if (redirect) begin
      // Redirect beats stall and HALT: flush everything and reload the PC.
      pc_d       = redirect_pc;
      pc_en      = 1'b1;
      hb_clear   = 1'b1;
      out_bubble = 1'b1;
      if (req && !imem.imem_ready) begin
        // Outstanding request must still complete; remember its address.
        state_next = ST_DRAIN;
        drain_en   = 1'b1;
      end else begin
        state_next = ST_FETCH;
      end
    end else begin
      case (state)
        ST_DRAIN: begin
          if (imem.imem_ready) begin
            state_next = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (accept) begin
            pc_en = 1'b1;
            if (is_halt(imem.imem_data)) begin
              state_next = ST_HALTED;
            end
          end
        end
        default: begin
          // HALTED: nothing to fetch; only the hold buffer may still drain.
        end
      endcase

      if (accept) begin
        if (stall) begin
          hb_load = 1'b1;
        end else begin
          out_load = 1'b1;
        end
      end else if (!stall) begin
        if (hb_valid) begin
          out_load = 1'b1;
          out_d    = hb_q;
          hb_clear = 1'b1;
        end else begin
          out_bubble = 1'b1;
        end
      end
    end
  end

  dff_16bit u_pc         (.clk(clk), .rst(rst), .en(pc_en),    .d(pc_d), .q(pc));
  dff_16bit u_drain_addr (.clk(clk), .rst(rst), .en(drain_en), .d(addr), .q(drain_addr));

  fetch_hold_buffer u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hb_load),
    .clear(hb_clear),
    .d    (fetched),
    .q    (hb_q),
    .valid(hb_valid)
  );

  // Output triple: PCs hold through bubbles, the instruction becomes NOP.
  assign inst_d = out_load ? out_d.inst : NOP_WORD;

  dff_16bit u_out_pc_curr (.clk(clk), .rst(rst), .en(out_load), .d(out_d.pc_curr), .q(PCCurrOut));
  dff_16bit u_out_pc_inc  (.clk(clk), .rst(rst), .en(out_load), .d(out_d.pc_inc),  .q(PCIncOut));
  dff_16bit #(.reset_value(NOP_WORD))
            u_out_inst    (.clk(clk), .rst(rst), .en(out_load | out_bubble), .d(inst_d), .q(InstOut));

  // Valid flag follows the output register: set on a real load, cleared on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
    end else if (out_load || out_bubble) begin
      fetch_valid <= out_load;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream model of the fetch stage.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        fetch_valid;
  logic [15:0] PCCurrOut, PCIncOut, InstOut;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (imem_bus),
    .fetch_valid(fetch_valid),
    .PCCurrOut  (PCCurrOut),
    .PCIncOut   (PCIncOut),
    .InstOut    (InstOut)
  );

  always #5 clk = ~clk;

  // Instruction memory model with fixed or random per-request latency.
  logic [15:0] mem [0:65535];
  int          mem_latency = 0;
  bit          mem_rand    = 1'b0;
  int          wait_cnt    = 0;
  int          rand_lat    = 0;
  int          eff_lat;

  assign eff_lat             = mem_rand ? rand_lat : mem_latency;
  assign imem_bus.imem_ready = imem_bus.imem_req && (wait_cnt >= eff_lat);
  assign imem_bus.imem_data  = imem_bus.imem_ready ? mem[imem_bus.imem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (rst || !imem_bus.imem_req || imem_bus.imem_ready) begin
      wait_cnt <= 0;
      rand_lat <= $urandom_range(0, 3);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  logic [48:0] obs;
  assign obs = {fetch_valid, PCCurrOut, PCIncOut, InstOut};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [48:0] trip(input logic v, input logic [15:0] pc, input logic [15:0] inst);
    logic [15:0] inc;
    inc = pc + 16'd2;
    return {v, pc, inc, inst};
  endfunction

  function automatic logic [15:0] non_halt_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_rand = 1'b0; mem_latency = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 16'h0000, 16'h0000, NOP}) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b0, 16'h0000, 16'h0000, NOP});
    end
    n_checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL reset_request: got req=%b addr=%h want req=1 addr=0000", imem_bus.imem_req, imem_bus.imem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0000, 16'h1234)) begin
      n_fail++; $display("FAIL first_fetch: got %h want %h", obs, trip(1'b1, 16'h0000, 16'h1234));
    end
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0002, 16'h5678)) begin
      n_fail++; $display("FAIL back_to_back: got %h want %h", obs, trip(1'b1, 16'h0002, 16'h5678));
    end
  endtask

  task automatic test_stall_latency();
    logic [48:0] held;
    bit dropped;
    held = trip(1'b1, 16'h0002, 16'h5678);
    dropped = 1'b0;
    mem_latency = 3;
    stall = 1'b1;
    for (int i = 0; i < 10 && !dropped; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== held) begin
        n_fail++; $display("FAIL stall_hold: got %h want %h", obs, held);
      end
      if (!imem_bus.imem_req) dropped = 1'b1;
    end
    n_checks++;
    if (!dropped) begin
      n_fail++; $display("FAIL stall_req_drop: imem_req got 1 want 0 within 10 cycles");
    end
    @(negedge clk);
    n_checks++;
    if ({imem_bus.imem_req, obs} !== {1'b0, held}) begin
      n_fail++; $display("FAIL stall_buffered: got req=%b out=%h want req=0 out=%h", imem_bus.imem_req, obs, held);
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0004, mem[4])) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", obs, trip(1'b1, 16'h0004, mem[4]));
    end
    n_checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 16'h0006}) begin
      n_fail++; $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=0006", imem_bus.imem_req, imem_bus.imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    bit saw_ready;
    saw_ready = 1'b0;
    mem[8] = 16'hBEEF;
    mem_latency = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0006, mem[6])) begin
      n_fail++; $display("FAIL fetch_6: got %h want %h", obs, trip(1'b1, 16'h0006, mem[6]));
    end
    mem_latency = 3;
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr, fetch_valid, InstOut} !== {1'b1, 16'h0008, 1'b0, NOP}) begin
        n_fail++; $display("FAIL drain_hold: got req=%b addr=%h valid=%b inst=%h want req=1 addr=0008 valid=0 inst=0800",
                           imem_bus.imem_req, imem_bus.imem_addr, fetch_valid, InstOut);
      end
      if (imem_bus.imem_ready) begin
        saw_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!saw_ready) begin
      n_fail++; $display("FAIL drain_timeout: imem_ready got 0 want 1 within 10 cycles");
    end
    @(negedge clk);
    n_checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, fetch_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      n_fail++; $display("FAIL drain_done: got req=%b addr=%h valid=%b want req=1 addr=0040 valid=0",
                         imem_bus.imem_req, imem_bus.imem_addr, fetch_valid);
    end
    mem_latency = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0040, mem[16'h0040])) begin
      n_fail++; $display("FAIL redirect_target: got %h want %h", obs, trip(1'b1, 16'h0040, mem[16'h0040]));
    end
  endtask

  task automatic test_redirect_stall();
    logic [48:0] bubble;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0;
    bubble = obs;
    n_checks++;
    if ({fetch_valid, InstOut, imem_bus.imem_req, imem_bus.imem_addr} !== {1'b0, NOP, 1'b1, 16'h0080}) begin
      n_fail++; $display("FAIL redirect_stall: got valid=%b inst=%h req=%b addr=%h want valid=0 inst=0800 req=1 addr=0080",
                         fetch_valid, InstOut, imem_bus.imem_req, imem_bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({imem_bus.imem_req, obs} !== {1'b0, bubble}) begin
      n_fail++; $display("FAIL redirect_stall_hold: got req=%b out=%h want req=0 out=%h", imem_bus.imem_req, obs, bubble);
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0080, mem[16'h0080])) begin
      n_fail++; $display("FAIL redirect_stall_release: got %h want %h", obs, trip(1'b1, 16'h0080, mem[16'h0080]));
    end
  endtask

  task automatic test_halt();
    mem[16'h0010] = 16'h0000;
    redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({obs, imem_bus.imem_req} !== {trip(1'b1, 16'h0010, 16'h0000), 1'b0}) begin
      n_fail++; $display("FAIL halt_offer: got out=%h req=%b want out=%h req=0", obs, imem_bus.imem_req, trip(1'b1, 16'h0010, 16'h0000));
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({imem_bus.imem_req, obs} !== {1'b0, 1'b0, 16'h0010, 16'h0012, NOP}) begin
        n_fail++; $display("FAIL halted_idle: got req=%b out=%h want req=0 out=%h", imem_bus.imem_req, obs, {1'b0, 16'h0010, 16'h0012, NOP});
      end
    end
    redirect = 1'b1; redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, fetch_valid} !== {1'b1, 16'h0020, 1'b0}) begin
      n_fail++; $display("FAIL halt_resume_req: got req=%b addr=%h valid=%b want req=1 addr=0020 valid=0",
                         imem_bus.imem_req, imem_bus.imem_addr, fetch_valid);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0020, mem[16'h0020])) begin
      n_fail++; $display("FAIL halt_resume_out: got %h want %h", obs, trip(1'b1, 16'h0020, mem[16'h0020]));
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFE] = 16'h4321;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 16'hFFFE, 16'h0000, 16'h4321}) begin
      n_fail++; $display("FAIL wrap_out: got %h want %h", obs, {1'b1, 16'hFFFE, 16'h0000, 16'h4321});
    end
    n_checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL wrap_next_req: got req=%b addr=%h want req=1 addr=0000", imem_bus.imem_req, imem_bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== trip(1'b1, 16'h0000, 16'h1234)) begin
      n_fail++; $display("FAIL wrap_follow: got %h want %h", obs, trip(1'b1, 16'h0000, 16'h1234));
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 1'b0;
    mem_latency = 3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({obs, imem_bus.imem_req, imem_bus.imem_addr} !== {1'b0, 16'h0000, 16'h0000, NOP, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL reset_mid: got out=%h req=%b addr=%h want out=%h req=1 addr=0000",
                         obs, imem_bus.imem_req, imem_bus.imem_addr, {1'b0, 16'h0000, 16'h0000, NOP});
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (fetch_valid) got = 1'b1;
    end
    n_checks++;
    if (obs !== trip(1'b1, 16'h0000, 16'h1234)) begin
      n_fail++; $display("FAIL reset_mid_first: got %h want %h", obs, trip(1'b1, 16'h0000, 16'h1234));
    end
  endtask

  // Randomized run: the model tracks only the expected instruction stream.
  task automatic test_random();
    logic [15:0] exp_pc, prev_rpc, prev_addr;
    logic [48:0] prev_obs;
    bit          prev_stall, prev_redir, prev_pending;
    int          delivered;
    delivered = 0;
    exp_pc = 16'h0000;
    mem[16'h0010] = non_halt_word();
    mem_rand = 1'b1;
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'($urandom) & 16'hFFFE;
    prev_stall = stall; prev_redir = redirect; prev_rpc = redirect_pc;
    prev_obs = obs;
    prev_pending = imem_bus.imem_req && !imem_bus.imem_ready;
    prev_addr = imem_bus.imem_addr;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (prev_redir) begin
        exp_pc = prev_rpc;
        if ({fetch_valid, InstOut} !== {1'b0, NOP}) begin
          n_fail++; $display("FAIL rand_flush: cycle %0d got valid=%b inst=%h want valid=0 inst=0800", cyc, fetch_valid, InstOut);
        end
      end else if (prev_stall) begin
        if (obs !== prev_obs) begin
          n_fail++; $display("FAIL rand_stall_hold: cycle %0d got %h want %h", cyc, obs, prev_obs);
        end
      end else if (fetch_valid) begin
        if (obs !== trip(1'b1, exp_pc, mem[exp_pc])) begin
          n_fail++; $display("FAIL rand_stream: cycle %0d got %h want %h", cyc, obs, trip(1'b1, exp_pc, mem[exp_pc]));
        end
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end else if (InstOut !== NOP) begin
        n_fail++; $display("FAIL rand_bubble: cycle %0d got inst=%h want 0800", cyc, InstOut);
      end
      if (prev_pending) begin
        n_checks++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, prev_addr}) begin
          n_fail++; $display("FAIL rand_addr_stable: cycle %0d got req=%b addr=%h want req=1 addr=%h",
                             cyc, imem_bus.imem_req, imem_bus.imem_addr, prev_addr);
        end
      end
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      stall       = ($urandom_range(0, 3) == 0);
      prev_stall = stall; prev_redir = redirect; prev_rpc = redirect_pc;
      prev_obs = obs;
      prev_pending = imem_bus.imem_req && !imem_bus.imem_ready;
      prev_addr = imem_bus.imem_addr;
    end
    redirect = 1'b0; stall = 1'b0;
    n_checks++;
    if (!(delivered > 300)) begin
      n_fail++; $display("FAIL rand_progress: got %0d instructions want more than 300", delivered);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = non_halt_word();
    mem[0] = 16'h1234;
    mem[2] = 16'h5678;
    test_reset();
    test_stall_latency();
    test_redirect_drain();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
